// File: rtl/branch_cond_unit.sv
// ============================================================================
// Module      : branch_cond_unit
// Description : Conditional-branch evaluator. Accepts a branch request,
//               waits for the ALU flags to settle, evaluates a 4-bit
//               condition code and returns taken/not-taken together with
//               a one-cycle PC-load strike for the fetch stage.
//               Optional feature macro: BRANCH_STATS_EN (taken / not-taken
//               saturating statistics counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond_unit #(
  parameter int ADDR_W = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cy,
  input  logic              ov,
  input  logic              zf,
  input  logic              sf,
  input  logic              flags_busy,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic              res_err,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_ntkn
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cond_q, cond_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                taken_q, taken_d;
  logic                err_q, err_d;
  logic                pc_load_q, pc_load_d;

  logic                eval_taken;
  logic                eval_err;
  logic                accept;
  logic                handshake;

  // Request acceptance and result handshake; flush blocks both.
  assign accept    = (state_q == S_IDLE) && br_valid && !flush;
  assign handshake = (state_q == S_RESP) && res_ready && !flush;

  assign br_ready  = (state_q == S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign res_taken = taken_q;
  assign res_err   = err_q;
  assign pc_load   = pc_load_q;
  assign pc_target = target_q;

  // Condition-code decode against the live flag values.
  always_comb begin
    eval_taken = 1'b0;
    eval_err   = 1'b0;
    case (cond_q)
      4'd0:    eval_taken = 1'b1;
      4'd1:    eval_taken = zf;
      4'd2:    eval_taken = !zf;
      4'd3:    eval_taken = cy;
      4'd4:    eval_taken = !cy;
      4'd5:    eval_taken = sf;
      4'd6:    eval_taken = !sf;
      4'd7:    eval_taken = ov;
      4'd8:    eval_taken = !ov;
      4'd9:    eval_taken = sf ^ ov;
      4'd10:   eval_taken = !(sf ^ ov);
      4'd11:   eval_taken = !zf && !(sf ^ ov);
      4'd12:   eval_taken = zf || (sf ^ ov);
      default: eval_err   = 1'b1;
    endcase
  end

  // Next-state and datapath logic; flush overrides everything at the end.
  always_comb begin
    state_d   = state_q;
    cond_d    = cond_q;
    target_d  = target_q;
    taken_d   = taken_q;
    err_d     = err_q;
    pc_load_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cond_d   = br_cond;
          target_d = br_target;
          state_d  = flags_busy ? S_WAIT : S_EVAL;
        end
      end
      S_WAIT: begin
        if (!flags_busy) state_d = S_EVAL;
      end
      S_EVAL: begin
        taken_d = eval_taken;
        err_d   = eval_err;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          pc_load_d = taken_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      pc_load_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cond_q    <= 4'd0;
      target_q  <= '0;
      taken_q   <= 1'b0;
      err_q     <= 1'b0;
      pc_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cond_q    <= cond_d;
      target_q  <= target_d;
      taken_q   <= taken_d;
      err_q     <= err_d;
      pc_load_q <= pc_load_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_taken_q, stat_taken_d;
  logic [STAT_W-1:0] stat_ntkn_q, stat_ntkn_d;

  // Saturating counters bumped on each result handshake; clear has priority.
  always_comb begin
    stat_taken_d = stat_taken_q;
    stat_ntkn_d  = stat_ntkn_q;
    if (stat_clr) begin
      stat_taken_d = '0;
      stat_ntkn_d  = '0;
    end else if (handshake) begin
      if (taken_q) begin
        if (!(&stat_taken_q)) stat_taken_d = stat_taken_q + 1'b1;
      end else begin
        if (!(&stat_ntkn_q)) stat_ntkn_d = stat_ntkn_q + 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_taken_q <= '0;
      stat_ntkn_q  <= '0;
    end else begin
      stat_taken_q <= stat_taken_d;
      stat_ntkn_q  <= stat_ntkn_d;
    end
  end

  assign stat_taken = stat_taken_q;
  assign stat_ntkn  = stat_ntkn_q;
`else
  logic unused_stat;

  assign unused_stat = stat_clr ^ handshake;
  assign stat_taken  = '0;
  assign stat_ntkn   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
// ============================================================================
// Module      : tb_branch_cond_unit
// Description : Directed self-checking bench for branch_cond_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_branch_cond_unit;

  localparam int ADDR_W = 8;
`ifdef BRANCH_STATS_EN
  localparam int STAT_W = 2;
`else
  localparam int STAT_W = 16;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              cy = 1'b0, ov = 1'b0, zf = 1'b0, sf = 1'b0;
  logic              flags_busy = 1'b0;
  logic              br_valid = 1'b0;
  logic              br_ready;
  logic [3:0]        br_cond = 4'd0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic              res_taken;
  logic              res_err;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              stat_clr = 1'b0;
  logic [STAT_W-1:0] stat_taken;
  logic [STAT_W-1:0] stat_ntkn;

  int checks = 0;
  int errors = 0;

  branch_cond_unit #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cy(cy), .ov(ov), .zf(zf), .sf(sf),
    .flags_busy(flags_busy),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_target(br_target),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_taken(res_taken), .res_err(res_err),
    .pc_load(pc_load), .pc_target(pc_target),
    .stat_clr(stat_clr), .stat_taken(stat_taken), .stat_ntkn(stat_ntkn)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with flags_busy low; returns observed values only.
  task automatic do_txn(input logic [3:0] c, input logic [ADDR_W-1:0] t,
                        output logic v_eval, output logic v_resp,
                        output logic tk, output logic er,
                        output logic [ADDR_W-1:0] tg,
                        output logic pl, output logic v_after);
    br_valid = 1'b1; br_cond = c; br_target = t;
    tick();
    br_valid = 1'b0;
    v_eval = res_valid;
    tick();
    v_resp = res_valid; tk = res_taken; er = res_err; tg = pc_target;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    pl = pc_load; v_after = res_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (br_ready !== 1'b1 || res_valid !== 1'b0 || pc_load !== 1'b0 || pc_target !== 8'h00) begin
      errors++;
      $display("FAIL reset: br_ready=%b res_valid=%b pc_load=%b pc_target=%h, want 1 0 0 00",
               br_ready, res_valid, pc_load, pc_target);
    end
    @(negedge clk); rst = 1'b0;
    tick();
    checks++;
    if (br_ready !== 1'b1 || res_valid !== 1'b0 || res_taken !== 1'b0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: br_ready=%b res_valid=%b taken=%b err=%b, want 1 0 0 0",
               br_ready, res_valid, res_taken, res_err);
    end
  endtask

  task automatic test_eq();
    logic ve, vr, tk, er, pl, va; logic [ADDR_W-1:0] tg;
    cy = 0; ov = 0; zf = 1; sf = 0;
    do_txn(4'd1, 8'h3C, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (ve !== 1'b0 || vr !== 1'b1) begin
      errors++; $display("FAIL eq_latency: valid N+1=%b N+2=%b, want 0 1", ve, vr);
    end
    checks++;
    if (tk !== 1'b1 || er !== 1'b0 || tg !== 8'h3C) begin
      errors++; $display("FAIL eq_result: taken=%b err=%b target=%h, want 1 0 3c", tk, er, tg);
    end
    checks++;
    if (pl !== 1'b1 || va !== 1'b0) begin
      errors++; $display("FAIL eq_pc_load: pc_load=%b res_valid=%b, want 1 0", pl, va);
    end
    tick();
    checks++;
    if (pc_load !== 1'b0) begin
      errors++; $display("FAIL eq_pulse_width: pc_load=%b, want 0", pc_load);
    end
  endtask

  task automatic test_gt_lt();
    logic ve, vr, tk, er, pl, va; logic [ADDR_W-1:0] tg;
    cy = 0; ov = 0; zf = 0; sf = 1;
    do_txn(4'd11, 8'h55, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (tk !== 1'b0 || pl !== 1'b0) begin
      errors++; $display("FAIL gt: taken=%b pc_load=%b, want 0 0", tk, pl);
    end
    do_txn(4'd9, 8'h66, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (tk !== 1'b1 || pl !== 1'b1 || tg !== 8'h66) begin
      errors++; $display("FAIL lt: taken=%b pc_load=%b target=%h, want 1 1 66", tk, pl, tg);
    end
  endtask

  // All 16 codes under two flag sets; expected taken bit per code hand-derived.
  task automatic test_cond_table();
    logic ve, vr, tk, er, pl, va; logic [ADDR_W-1:0] tg;
    logic [15:0] exp_a, exp_b, exp_v;
    exp_a = 16'h12CD;  // cy=1 ov=1 zf=0 sf=0
    exp_b = 16'h1333;  // cy=0 ov=0 zf=1 sf=1
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin cy = 1; ov = 1; zf = 0; sf = 0; exp_v = exp_a; end
      else        begin cy = 0; ov = 0; zf = 1; sf = 1; exp_v = exp_b; end
      for (int c = 0; c < 16; c++) begin
        do_txn(c[3:0], 8'(c + 8'h10), ve, vr, tk, er, tg, pl, va);
        checks++;
        if (tk !== exp_v[c] || er !== (c >= 13) || pl !== exp_v[c]) begin
          errors++;
          $display("FAIL cond_table set=%0d cond=%0d: taken=%b err=%b pc_load=%b, want %b %b %b",
                   s, c, tk, er, pl, exp_v[c], (c >= 13), exp_v[c]);
        end
      end
    end
  endtask

  task automatic test_reserved();
    logic ve, vr, tk, er, pl, va; logic [ADDR_W-1:0] tg;
    cy = 1; ov = 1; zf = 1; sf = 1;
    do_txn(4'hE, 8'h77, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (er !== 1'b1 || tk !== 1'b0 || pl !== 1'b0 || vr !== 1'b1) begin
      errors++; $display("FAIL reserved: err=%b taken=%b pc_load=%b valid=%b, want 1 0 0 1",
                         er, tk, pl, vr);
    end
  endtask

  task automatic test_busy();
    logic ok;
    cy = 0; ov = 0; sf = 0; zf = 0;   // wrong flags while busy
    flags_busy = 1'b1;
    br_valid = 1'b1; br_cond = 4'd1; br_target = 8'h42;
    tick();                            // accept edge, busy sampled
    br_valid = 1'b0;
    ok = (res_valid === 1'b0);
    tick();
    ok = ok && (res_valid === 1'b0);
    tick();
    flags_busy = 1'b0; zf = 1;         // first non-busy cycle, correct flags
    ok = ok && (res_valid === 1'b0);
    tick();                            // EVAL
    ok = ok && (res_valid === 1'b0);
    tick();                            // RESP
    checks++;
    if (!ok || res_valid !== 1'b1) begin
      errors++; $display("FAIL busy_latency: early_valid_ok=%b res_valid=%b, want 1 1", ok, res_valid);
    end
    checks++;
    if (res_taken !== 1'b1 || pc_target !== 8'h42) begin
      errors++; $display("FAIL busy_flags: taken=%b target=%h, want 1 42", res_taken, pc_target);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
      errors++; $display("FAIL resp_hold: valid=%b taken=%b, want 1 1", res_valid, res_taken);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (pc_load !== 1'b1) begin
      errors++; $display("FAIL busy_pc_load: pc_load=%b, want 1", pc_load);
    end
    tick();
  endtask

  task automatic test_flush();
    logic seen;
    zf = 1;
    flags_busy = 1'b1;
    br_valid = 1'b1; br_cond = 4'd0; br_target = 8'h11;
    tick();
    br_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0; flags_busy = 1'b0;
    checks++;
    if (br_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL flush_wait: br_ready=%b res_valid=%b, want 1 0", br_ready, res_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_valid !== 1'b0 || pc_load !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_quiet: activity=%b, want 0", seen);
    end
    // flush with br_valid in IDLE: no accept
    br_valid = 1'b1; flush = 1'b1; br_cond = 4'd0;
    tick();
    br_valid = 1'b0; flush = 1'b0;
    checks++;
    if (br_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle: br_ready=%b, want 1", br_ready);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_valid: res_valid=%b, want 0", res_valid);
    end
    // flush during RESP handshake: pc_load suppressed
    br_valid = 1'b1; br_cond = 4'd0; br_target = 8'h22;
    tick(); br_valid = 1'b0;
    tick();
    res_ready = 1'b1; flush = 1'b1;
    tick();
    res_ready = 1'b0; flush = 1'b0;
    checks++;
    if (pc_load !== 1'b0 || res_valid !== 1'b0 || br_ready !== 1'b1) begin
      errors++; $display("FAIL flush_resp: pc_load=%b res_valid=%b br_ready=%b, want 0 0 1",
                         pc_load, res_valid, br_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic ve, vr, tk, er, pl, va; logic [ADDR_W-1:0] tg;
    cy = 1; ov = 0; zf = 0; sf = 0;
    do_txn(4'd3, 8'hA0, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (br_ready !== 1'b1 || pl !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: br_ready=%b pc_load=%b, want 1 1", br_ready, pl);
    end
    do_txn(4'd4, 8'hA1, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (ve !== 1'b0 || vr !== 1'b1 || tk !== 1'b0 || tg !== 8'hA1 || pl !== 1'b0) begin
      errors++; $display("FAIL b2b_second: ve=%b vr=%b taken=%b target=%h pc_load=%b, want 0 1 0 a1 0",
                         ve, vr, tk, tg, pl);
    end
  endtask

  task automatic test_rst_mid();
    flags_busy = 1'b1;
    br_valid = 1'b1; br_cond = 4'd0; br_target = 8'hA5;
    tick();
    br_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (br_ready !== 1'b1 || res_valid !== 1'b0 || pc_target !== 8'h00) begin
      errors++; $display("FAIL rst_mid: br_ready=%b res_valid=%b pc_target=%h, want 1 0 00",
                         br_ready, res_valid, pc_target);
    end
    @(negedge clk); rst = 1'b0; flags_busy = 1'b0;
    tick(); tick();
    checks++;
    if (res_valid !== 1'b0 || br_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_lost: res_valid=%b br_ready=%b, want 0 1", res_valid, br_ready);
    end
  endtask

  task automatic test_stats();
    logic ve, vr, tk, er, pl, va; logic [ADDR_W-1:0] tg;
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_taken !== 2'd0 || stat_ntkn !== 2'd0) begin
      errors++; $display("FAIL stat_clr: taken=%0d ntkn=%0d, want 0 0", stat_taken, stat_ntkn);
    end
    for (int i = 0; i < 5; i++) do_txn(4'd0, 8'h01, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (stat_taken !== 2'd3 || stat_ntkn !== 2'd0) begin
      errors++; $display("FAIL stat_sat: taken=%0d ntkn=%0d, want 3 0", stat_taken, stat_ntkn);
    end
    do_txn(4'hF, 8'h02, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (stat_ntkn !== 2'd1 || stat_taken !== 2'd3) begin
      errors++; $display("FAIL stat_reserved: taken=%0d ntkn=%0d, want 3 1", stat_taken, stat_ntkn);
    end
    br_valid = 1'b1; br_cond = 4'd0; tick(); br_valid = 1'b0;
    tick();
    res_ready = 1'b1; stat_clr = 1'b1;
    tick();
    res_ready = 1'b0; stat_clr = 1'b0;
    checks++;
    if (stat_taken !== 2'd0 || stat_ntkn !== 2'd0) begin
      errors++; $display("FAIL stat_clr_hs: taken=%0d ntkn=%0d, want 0 0", stat_taken, stat_ntkn);
    end
`else
    for (int i = 0; i < 3; i++) do_txn(4'd0, 8'h01, ve, vr, tk, er, tg, pl, va);
    checks++;
    if (stat_taken !== 16'd0 || stat_ntkn !== 16'd0) begin
      errors++; $display("FAIL stat_off: taken=%0d ntkn=%0d, want 0 0", stat_taken, stat_ntkn);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_eq();
    test_gt_lt();
    test_cond_table();
    test_reserved();
    test_busy();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
